// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter.
//   tx_state_t   : FSM state encoding
//   PARITY_*     : parity mode constants for p_parity
//   clog2_int    : ceiling log2 for sizing counters
//   calc_div     : clock cycles per line bit (truncated)
//   parity_bit   : parity bit to send from the XOR of the data bits
package uart_tx_buffered_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic int clog2_int(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic int calc_div(input int clk_freq, input int baud_freq);
        return clk_freq / baud_freq;
    endfunction

    // data_xor is the XOR of all eight data bits (1 = odd number of ones).
    function automatic logic parity_bit(input logic data_xor, input int mode);
        return (mode == PARITY_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte handshake between a host and the UART transmitter.
//   tx_data  : byte to send
//   tx_valid : tx_data valid
//   tx_ready : transmitter can accept; byte taken on an edge with valid && ready
interface uart_tx_buffered_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Single-clock FIFO with first-word data on the read port.
//   i_clk, i_rst_n : clock, async active-low reset (empties the FIFO)
//   wr_en, wr_data : push (ignored when full)
//   rd_en          : pop (ignored when empty); rd_data is the head entry
//   full, empty    : derived from the registered count
//   count          : entries held
module uart_tx_buffered_sync_fifo #(
    parameter int p_width = 8,
    parameter int p_depth = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      wr_en,
    input  logic [p_width-1:0]        wr_data,
    input  logic                      rd_en,
    output logic [p_width-1:0]        rd_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(p_depth):0]  count
);
    localparam int AW = $clog2(p_depth);

    logic [p_width-1:0] mem [p_depth];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               do_wr;
    logic               do_rd;

    assign full    = (count == (AW+1)'(p_depth));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: bytes enter a FIFO over a valid/ready handshake
// and leave on o_tx as start, 8 data bits LSB first, optional parity, one stop.
//   i_clk, i_rst_n : clock, async active-low reset
//   tx_if          : byte handshake (slave side)
//   o_tx           : serial line, idle high, registered
//   o_tx_busy      : frame in progress
//   o_tx_done      : one-cycle pulse on the last cycle of each stop bit
//   o_fifo_count   : bytes queued, not counting the byte on the line
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | line high, waiting for a queued byte
// ST_START  | start bit (0) for one bit period
// ST_DATA   | data bits 0..7, LSB first, one bit period each
// ST_PARITY | parity bit (only when p_parity != 0)
// ST_STOP   | stop bit (1); chains straight into the next frame
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int p_clk_freq   = 50_000_000,
    parameter int p_baud_freq  = 115_200,
    parameter int p_fifo_depth = 16,
    parameter int p_parity     = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    uart_tx_buffered_if.slave             tx_if,
    output logic                          o_tx,
    output logic                          o_tx_busy,
    output logic                          o_tx_done,
    output logic [$clog2(p_fifo_depth):0] o_fifo_count
);
    localparam int DIV   = calc_div(p_clk_freq, p_baud_freq);
    localparam int CNT_W = clog2_int(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DIV - 2);

    tx_state_t        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             par_acc;
    logic             tx_q;
    logic             busy_q;
    logic             done_q;

    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       bit_end;
    logic [7:0] fifo_rd_data;

    uart_tx_buffered_sync_fifo #(
        .p_width (8),
        .p_depth (p_fifo_depth)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .wr_en   (tx_if.tx_valid),
        .wr_data (tx_if.tx_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (o_fifo_count)
    );

    assign tx_if.tx_ready = !fifo_full;
    assign o_tx      = tx_q;
    assign o_tx_busy = busy_q;
    assign o_tx_done = done_q;

    // A byte leaves the FIFO either from idle or on the last stop-bit cycle,
    // so consecutive frames have no idle gap between them.
    always_comb begin
        bit_end  = (baud_cnt == CNT_LAST);
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            fifo_pop = (state == ST_IDLE) || ((state == ST_STOP) && bit_end);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            par_acc   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (fifo_pop) begin
                        shift_reg <= fifo_rd_data;
                        par_acc   <= 1'b0;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx_q     <= shift_reg[0];
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt  <= '0;
                        par_acc   <= par_acc ^ shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            if (p_parity != PARITY_NONE) begin
                                tx_q  <= parity_bit(par_acc ^ shift_reg[0], p_parity);
                                state <= ST_PARITY;
                            end else begin
                                tx_q  <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_q    <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx_q     <= 1'b1;
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (fifo_pop) begin
                            shift_reg <= fifo_rd_data;
                            par_acc   <= 1'b0;
                            tx_q      <= 1'b0;
                            state     <= ST_START;
                        end else begin
                            busy_q <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                        // Registered pulse lands on the final stop-bit cycle.
                        if (baud_cnt == CNT_DONE) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    baud_cnt <= '0;
                    tx_q     <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
